// File: rtl/sim_run_controller_pkg.sv
// Shared state encoding and exit constants for the simulation run controller.
// Imported by the RTL and by the testbench for state decoding.
package sim_run_controller_pkg;

    typedef enum logic [2:0] {
        StRstHold = 3'd0,
        StRun     = 3'd1,
        StPass    = 3'd2,
        StFail    = 3'd3,
        StTimeout = 3'd4
    } run_state_e;

    localparam int unsigned TOHOST_PASS = 1;

    function automatic logic is_terminal(input run_state_e s);
        return (s == StPass) || (s == StFail) || (s == StTimeout);
    endfunction

endpackage

// File: rtl/sim_run_controller_sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
// Used for the RUN cycle and retired-instruction counts.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (en && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// Run controller between bench and CPU: sequences CPU reset, counts cycles and
// retires, and detects the tohost exit write to report pass, fail or timeout.
module sim_run_controller
    import sim_run_controller_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     RESET_CYCLES = 2,
    parameter int unsigned     MAX_CYCLES   = 100,
    parameter logic [XLEN-1:0] TOHOST_ADDR  = 32'h0000_1000,
    parameter int unsigned     CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_we,
    input  logic [XLEN-1:0]  mem_addr,
    input  logic [XLEN-1:0]  mem_wdata,
    input  logic             retire,
    output logic             cpu_reset,
    output logic             running,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-2:0]  exit_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret_count
);

    // Compare width wide enough for both the counter and the 32-bit budget.
    localparam int unsigned CMPW = (CNT_W > 32) ? CNT_W : 32;

    run_state_e  state;
    logic [31:0] hold;
    logic        in_run;
    logic        exit_hit;
    logic        timeout_hit;

    assign in_run   = (state == StRun);
    assign exit_hit = in_run && mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];

    always_comb begin
        timeout_hit = 1'b0;
        if (in_run && (MAX_CYCLES != 0)) begin
            timeout_hit = (CMPW'(cycle_count) == CMPW'(MAX_CYCLES - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StRstHold;
            hold      <= '0;
            cpu_reset <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            exit_code <= '0;
        end else begin
            case (state)
                StRstHold: begin
                    if (hold == RESET_CYCLES - 1) begin
                        state     <= StRun;
                        cpu_reset <= 1'b0;
                        running   <= 1'b1;
                    end else begin
                        hold <= hold + 32'd1;
                    end
                end
                StRun: begin
                    // Exit write takes priority over a coincident timeout.
                    if (exit_hit) begin
                        cpu_reset <= 1'b1;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        if (mem_wdata == XLEN'(TOHOST_PASS)) begin
                            state <= StPass;
                            pass  <= 1'b1;
                        end else begin
                            state     <= StFail;
                            fail      <= 1'b1;
                            exit_code <= mem_wdata[XLEN-1:1];
                        end
                    end else if (timeout_hit) begin
                        state     <= StTimeout;
                        cpu_reset <= 1'b1;
                        running   <= 1'b0;
                        done      <= 1'b1;
                        timeout   <= 1'b1;
                    end
                end
                default: begin
                    // Terminal states hold until reset.
                    if (!is_terminal(state)) begin
                        state <= StRstHold;
                    end
                end
            endcase
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .clear (reset),
        .en    (in_run),
        .count (cycle_count)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_instret_cnt (
        .clk   (clk),
        .clear (reset),
        .en    (in_run && retire),
        .count (instret_count)
    );

endmodule

// File: tb/tb_sim_run_controller.sv
// Directed bench for sim_run_controller: a default instance plus one with a long
// reset hold, no timeout and 4-bit counters, driven from shared stimulus.
module tb_sim_run_controller;
    import sim_run_controller_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        we_a;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        retire;

    logic        a_cpu_reset, a_running, a_done, a_pass, a_fail, a_timeout;
    logic [30:0] a_exit;
    logic [31:0] a_cycle, a_instret;

    logic        b_cpu_reset, b_running, b_done, b_pass, b_fail, b_timeout;
    logic [30:0] b_exit;
    logic [3:0]  b_cycle, b_instret;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sim_run_controller u_dut_a (
        .clk           (clk),
        .reset         (reset),
        .mem_we        (we_a),
        .mem_addr      (addr),
        .mem_wdata     (wdata),
        .retire        (retire),
        .cpu_reset     (a_cpu_reset),
        .running       (a_running),
        .done          (a_done),
        .pass          (a_pass),
        .fail          (a_fail),
        .timeout       (a_timeout),
        .exit_code     (a_exit),
        .cycle_count   (a_cycle),
        .instret_count (a_instret)
    );

    sim_run_controller #(
        .RESET_CYCLES (5),
        .MAX_CYCLES   (0),
        .CNT_W        (4)
    ) u_dut_b (
        .clk           (clk),
        .reset         (reset),
        .mem_we        (1'b0),
        .mem_addr      (addr),
        .mem_wdata     (wdata),
        .retire        (retire),
        .cpu_reset     (b_cpu_reset),
        .running       (b_running),
        .done          (b_done),
        .pass          (b_pass),
        .fail          (b_fail),
        .timeout       (b_timeout),
        .exit_code     (b_exit),
        .cycle_count   (b_cycle),
        .instret_count (b_instret)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset, then release and wait out the default two-cycle hold of instance a.
    task automatic start_run();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (2) step();
    endtask

    task automatic check_a_reset(input string tag);
        check({tag, "_cpu_reset"}, 64'(a_cpu_reset), 64'd1);
        check({tag, "_running"},   64'(a_running),   64'd0);
        check({tag, "_done"},      64'(a_done),      64'd0);
        check({tag, "_flags"},     64'({a_pass, a_fail, a_timeout}), 64'd0);
        check({tag, "_exit"},      64'(a_exit),      64'd0);
        check({tag, "_cycle"},     64'(a_cycle),     64'd0);
        check({tag, "_instret"},   64'(a_instret),   64'd0);
    endtask

    initial begin
        reset  = 1'b1;
        we_a   = 1'b0;
        addr   = 32'h0;
        wdata  = 32'h0;
        retire = 1'b0;
        step();
        step();
        check_a_reset("rst");
        check("rst_b_cpu_reset", 64'(b_cpu_reset), 64'd1);

        // Reset release timing for hold lengths 2 and 5.
        reset = 1'b0;
        step();
        check("hold2_e1_cpu_reset", 64'(a_cpu_reset), 64'd1);
        step();
        check("hold2_e2_cpu_reset", 64'(a_cpu_reset), 64'd0);
        check("hold2_e2_running",   64'(a_running),   64'd1);
        check("hold2_e2_cycle",     64'(a_cycle),     64'd0);
        step();
        step();
        check("hold5_e4_cpu_reset", 64'(b_cpu_reset), 64'd1);
        step();
        check("hold5_e5_cpu_reset", 64'(b_cpu_reset), 64'd0);
        check("hold5_e5_running",   64'(b_running),   64'd1);

        // Pass at RUN cycle 40, retire on alternate cycles for the first 20.
        start_run();
        for (int i = 0; i < 40; i++) begin
            retire = (i < 20) && (i % 2 == 0);
            step();
        end
        retire = 1'b0;
        check("t1_pre_cycle",   64'(a_cycle),   64'd40);
        check("t1_pre_done",    64'(a_done),    64'd0);
        check("t1_instret",     64'(a_instret), 64'd10);
        we_a  = 1'b1;
        addr  = 32'h0000_1000;
        wdata = 32'h0000_0001;
        step();
        we_a = 1'b0;
        check("t1_pass",      64'(a_pass),      64'd1);
        check("t1_done",      64'(a_done),      64'd1);
        check("t1_fail_tmo",  64'({a_fail, a_timeout}), 64'd0);
        check("t1_running",   64'(a_running),   64'd0);
        check("t1_exit",      64'(a_exit),      64'd0);
        check("t1_cycle",     64'(a_cycle),     64'd41);
        check("t1_cpu_reset", 64'(a_cpu_reset), 64'd1);
        retire = 1'b1;
        we_a   = 1'b1;
        wdata  = 32'h0000_0007;
        repeat (3) step();
        retire = 1'b0;
        we_a   = 1'b0;
        check("t1_sticky_pass",    64'(a_pass),    64'd1);
        check("t1_sticky_fail",    64'(a_fail),    64'd0);
        check("t1_sticky_cycle",   64'(a_cycle),   64'd41);
        check("t1_sticky_instret", 64'(a_instret), 64'd10);

        // Ignored writes, then a failing exit code.
        start_run();
        repeat (5) step();
        we_a  = 1'b1;
        addr  = 32'h0000_1000;
        wdata = 32'h0000_0002;
        step();
        check("t4_even_ignored", 64'(a_done), 64'd0);
        addr  = 32'h0000_1004;
        wdata = 32'h0000_0001;
        step();
        check("t4_addr_ignored", 64'(a_done), 64'd0);
        we_a = 1'b0;
        addr = 32'h0000_1000;
        step();
        check("t4_we_low_ignored", 64'(a_done), 64'd0);
        we_a  = 1'b1;
        wdata = 32'h0000_0007;
        step();
        we_a = 1'b0;
        check("t2_fail",  64'(a_fail),  64'd1);
        check("t2_pass",  64'(a_pass),  64'd0);
        check("t2_done",  64'(a_done),  64'd1);
        check("t2_exit",  64'(a_exit),  64'd3);
        check("t2_cycle", 64'(a_cycle), 64'd9);
        we_a  = 1'b1;
        wdata = 32'h0000_0001;
        step();
        we_a = 1'b0;
        check("t2_late_fail", 64'(a_fail), 64'd1);
        check("t2_late_pass", 64'(a_pass), 64'd0);
        check("t2_late_exit", 64'(a_exit), 64'd3);

        start_run();
        we_a  = 1'b1;
        wdata = 32'hFFFF_FFFF;
        step();
        we_a = 1'b0;
        check("t2_wide_exit", 64'(a_exit), 64'h7FFF_FFFF);

        // Timeout after 100 RUN cycles; the prior failure must be forgotten.
        start_run();
        check("t3_cleared_fail", 64'(a_fail), 64'd0);
        check("t3_cleared_exit", 64'(a_exit), 64'd0);
        repeat (99) step();
        check("t3_pre_done",  64'(a_done),  64'd0);
        check("t3_pre_cycle", 64'(a_cycle), 64'd99);
        step();
        check("t3_timeout",   64'(a_timeout),   64'd1);
        check("t3_done",      64'(a_done),      64'd1);
        check("t3_pass_fail", 64'({a_pass, a_fail}), 64'd0);
        check("t3_cycle",     64'(a_cycle),     64'd100);
        check("t3_cpu_reset", 64'(a_cpu_reset), 64'd1);
        repeat (5) step();
        check("t3_cycle_hold", 64'(a_cycle), 64'd100);

        // Exit write on the last budgeted cycle beats the timeout.
        start_run();
        repeat (99) step();
        we_a  = 1'b1;
        wdata = 32'h0000_0001;
        step();
        we_a = 1'b0;
        check("t4_tie_pass",    64'(a_pass),    64'd1);
        check("t4_tie_timeout", 64'(a_timeout), 64'd0);
        check("t4_tie_cycle",   64'(a_cycle),   64'd100);

        // Reset pulsed mid-RUN.
        start_run();
        repeat (30) step();
        check("t5_mid_cycle", 64'(a_cycle), 64'd30);
        reset = 1'b1;
        step();
        check_a_reset("t5_mid");
        reset = 1'b0;
        step();
        check("t5_restart_e1", 64'(a_cpu_reset), 64'd1);
        step();
        check("t5_restart_e2",  64'(a_cpu_reset), 64'd0);
        check("t5_restart_run", 64'(a_running),   64'd1);

        // Instance b: saturation at 15 and no timeout over 500 cycles.
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (5) step();
        check("t6_b_running", 64'(b_running), 64'd1);
        check("t6_b_cycle0",  64'(b_cycle),   64'd0);
        retire = 1'b1;
        repeat (20) step();
        retire = 1'b0;
        check("t6_b_instret_sat", 64'(b_instret), 64'd15);
        check("t6_b_cycle_sat",   64'(b_cycle),   64'd15);
        repeat (480) step();
        check("t3_b_no_done",    64'(b_done),    64'd0);
        check("t3_b_no_timeout", 64'(b_timeout), 64'd0);
        check("t3_b_running",    64'(b_running), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
